// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
//   Bundles the fetch unit's external buses: the instruction ROM read port,
//   the redirect port from execute/branch resolution and the valid/ready
//   handshake towards decode.
//
//   master : the fetch unit (drives rom_addr and the out_* handshake)
//   slave  : the surroundings (ROM, execute, decode)
//
//   rom_addr        ROM word address
//   rom_data        ROM read data, combinational in rom_addr
//   redirect_valid  restart fetch at redirect_pc and flush
//   redirect_pc     new fetch PC
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head
//   out_pc          PC of the head entry
//   out_inst        instruction of the head entry
//   out_fault       head entry is a fetch fault
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if #(
    parameter int ROM_AW = 11
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              redirect_valid;
    logic [63:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_pc;
    logic [31:0]       out_inst;
    logic              out_fault;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_fault
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_fault
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch front end. Owns the 64-bit PC, addresses an asynchronous
//   instruction ROM, and buffers {pc, inst, fault} entries in a small FIFO that
//   feeds decode. A misaligned or out-of-range PC produces one fault entry
//   carrying a NOP and halts fetch until the next redirect.
//
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  inst_fetch_unit_if.master (ROM port, redirect port, decode handshake)
//
//   Parameters: RESET_PC (PC after reset), ROM_AW (ROM word-address width),
//   DEPTH (FIFO entries, power of two, >= 2).
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          ROM_AW   = 11,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    state_t         state, state_nxt;
    logic [63:0]    pc;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    entry_t         mem [DEPTH];
    entry_t         last;      // last head shown, held while the FIFO is empty
    entry_t         head;
    entry_t         wr_entry;
    logic           fault;
    logic           push;
    logic           pop;

    assign bus.rom_addr = pc[ROM_AW+1:2];

    assign fault = (pc[1:0] != 2'b00) || (pc[63:ROM_AW+2] != '0);
    assign pop   = bus.out_valid && bus.out_ready;

    assign wr_entry.pc    = pc;
    assign wr_entry.inst  = fault ? NOP : bus.rom_data;
    assign wr_entry.fault = fault;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        if (bus.redirect_valid)  state_nxt = RUN;
        else if (push && fault)  state_nxt = HALT;
    end

    // ---------------- FSM: outputs ----------------
    // A full FIFO can still accept a push when the head leaves the same cycle.
    always_comb begin
        push = 1'b0;
        if (state == RUN && !bus.redirect_valid)
            push = (count < FULL) || pop;
    end

    // ---------------- PC, pointers, count ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (bus.out_valid) last <= head;
            if (bus.redirect_valid) begin
                // Redirect wins: the FIFO is discarded, including any entry
                // handshaked this cycle.
                pc     <= bus.redirect_pc;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (!fault) pc <= pc + 64'd4;
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // ---------------- FIFO storage ----------------
    // NOTE: the storage array is not reset; count gates every read, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head = (count != '0) ? mem[rd_ptr] : last;

    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.out_fault = head.fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Directed bench for inst_fetch_unit with a 2048-word ROM model whose word i
//   holds {16'hC0DE, i[15:0]}.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] rom [2048];

    inst_fetch_unit_if #(.ROM_AW(11)) bus ();

    inst_fetch_unit #(
        .RESET_PC (64'h0),
        .ROM_AW   (11),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = {16'hC0DE, 16'(i)};
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.out_ready      = 1'b1;

        // ---- reset state ----
        tick(); tick();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_pc",    bus.out_pc,         64'h0);
        check("rst_inst",  64'(bus.out_inst),  64'h0);
        check("rst_fault", 64'(bus.out_fault), 64'd0);
        check("rst_addr",  64'(bus.rom_addr),  64'h0);

        // ---- streaming with out_ready high ----
        rst = 1'b0;
        tick();
        check("s0_valid", 64'(bus.out_valid), 64'd1);
        check("s0_pc",    bus.out_pc,         64'h0);
        check("s0_inst",  64'(bus.out_inst),  64'hC0DE_0000);
        check("s0_fault", 64'(bus.out_fault), 64'd0);
        tick();
        check("s1_pc",    bus.out_pc,         64'h4);
        check("s1_inst",  64'(bus.out_inst),  64'hC0DE_0001);
        tick();
        check("s2_pc",    bus.out_pc,         64'h8);
        check("s2_inst",  64'(bus.out_inst),  64'hC0DE_0002);
        tick();
        check("s3_pc",    bus.out_pc,         64'hC);
        check("s3_inst",  64'(bus.out_inst),  64'hC0DE_0003);
        check("s3_fault", 64'(bus.out_fault), 64'd0);

        // ---- stall from reset: FIFO fills to 2, fetch freezes at pc 8 ----
        rst = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_addr",  64'(bus.rom_addr),  64'h2);
        check("stall_pc",    bus.out_pc,         64'h0);
        check("stall_inst",  64'(bus.out_inst),  64'hC0DE_0000);
        bus.out_ready = 1'b1;
        tick();
        check("rel0_pc",   bus.out_pc,        64'h4);
        check("rel0_inst", 64'(bus.out_inst), 64'hC0DE_0001);
        check("rel0_addr", 64'(bus.rom_addr), 64'h3);
        tick();
        check("rel1_pc",   bus.out_pc,        64'h8);
        check("rel1_inst", 64'(bus.out_inst), 64'hC0DE_0002);

        // ---- redirect to 0x100 while full with a pop pending ----
        redirect_to(64'h100);
        check("rd100_valid", 64'(bus.out_valid), 64'd0);
        check("rd100_addr",  64'(bus.rom_addr),  64'h40);
        tick();
        check("rd100_v1",   64'(bus.out_valid), 64'd1);
        check("rd100_pc",   bus.out_pc,         64'h100);
        check("rd100_inst", 64'(bus.out_inst),  64'hC0DE_0040);
        tick();
        check("rd104_pc",   bus.out_pc,         64'h104);
        check("rd104_inst", 64'(bus.out_inst),  64'hC0DE_0041);

        // ---- misaligned redirect: one fault entry, then HALT ----
        redirect_to(64'h102);
        check("mis_flush", 64'(bus.out_valid), 64'd0);
        tick();
        check("mis_valid", 64'(bus.out_valid), 64'd1);
        check("mis_pc",    bus.out_pc,         64'h102);
        check("mis_inst",  64'(bus.out_inst),  64'h13);
        check("mis_fault", 64'(bus.out_fault), 64'd1);
        tick();
        check("halt_v0", 64'(bus.out_valid), 64'd0);
        tick(); tick();
        check("halt_v1",   64'(bus.out_valid), 64'd0);
        check("halt_addr", 64'(bus.rom_addr),  64'h40);

        // ---- redirect out of HALT ----
        redirect_to(64'h8);
        tick();
        check("res_pc",    bus.out_pc,         64'h8);
        check("res_inst",  64'(bus.out_inst),  64'hC0DE_0002);
        check("res_fault", 64'(bus.out_fault), 64'd0);

        // ---- out-of-range redirect (bit 13 set with ROM_AW = 11) ----
        redirect_to(64'h2000);
        tick();
        check("oor_pc",    bus.out_pc,         64'h2000);
        check("oor_inst",  64'(bus.out_inst),  64'h13);
        check("oor_fault", 64'(bus.out_fault), 64'd1);
        tick(); tick();
        check("oor_halt",  64'(bus.out_valid), 64'd0);

        // ---- reset with a full FIFO and a pending redirect ----
        bus.out_ready = 1'b0;
        redirect_to(64'h40);
        tick(); tick();
        check("pre_valid", 64'(bus.out_valid), 64'd1);
        check("pre_pc",    bus.out_pc,         64'h40);
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h500;
        bus.out_ready      = 1'b1;
        tick();
        check("mr_valid", 64'(bus.out_valid), 64'd0);
        check("mr_addr",  64'(bus.rom_addr),  64'h0);
        check("mr_pc",    bus.out_pc,         64'h0);
        check("mr_inst",  64'(bus.out_inst),  64'h0);
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        check("post_pc",   bus.out_pc,        64'h0);
        check("post_inst", 64'(bus.out_inst), 64'hC0DE_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
